// File: rtl/imem_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned NBANK  = 8;
  localparam int unsigned AW     = 7;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam int unsigned BANK_W = $clog2(NBANK);
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned CNT_W  = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    BANK,
    COUNT,
    DATA,
    WRITE,
    CSUM
  } state_t;

  function automatic logic [NBANK-1:0] bank_onehot(input logic [BANK_W-1:0] b);
    return NBANK'(1) << b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
interface imem_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_word_pack.sv
// Little-endian byte-to-word packer with running XOR checksum.
module imem_word_pack (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_ok,
  input  logic [7:0]  byte_i,
  output logic        word_full,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic [7:0]  csum_q;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      csum_q <= '0;
    end else if (byte_ok) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      csum_q                       <= csum_q ^ byte_i;
      idx_q                        <= idx_q + 2'd1;
    end
  end

  assign word_full = byte_ok && (idx_q == 2'd3);
  assign word_o    = word_q;
  assign csum_o    = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, BANK, COUNT, COUNT*4 data bytes, CSUM -> bank RAM writes.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clka,
  input  logic              rst_n,
  imem_loader_if.slave      strm,
  input  logic              abort,
  output logic              we,
  output logic [BANK_W-1:0] wbank,
  output logic [AW-1:0]     waddr,
  output logic [31:0]       wdata,
  output logic [NBANK-1:0]  core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t             state_q, state_d;
  logic [BANK_W-1:0]  wbank_q, wbank_d;
  logic [NBANK-1:0]   hold_q, hold_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept, pack_clear, byte_ok, word_full;
  logic [7:0]         csum;

  assign strm.in_ready = (state_q != WRITE);
  assign accept        = strm.in_valid && strm.in_ready;

  imem_word_pack u_pack (
    .clka      (clka),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .byte_ok   (byte_ok),
    .byte_i    (strm.in_data),
    .word_full (word_full),
    .word_o    (wdata),
    .csum_o    (csum)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wbank_q <= '0;
      hold_q  <= '0;
      waddr_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wbank_q <= wbank_d;
      hold_q  <= hold_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wbank_d    = wbank_q;
    hold_d     = hold_q;
    waddr_d    = waddr_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pack_clear = 1'b0;
    byte_ok    = 1'b0;
    // abort outranks any byte transferred in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      hold_d  = '0;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (accept && (strm.in_data == SYNC)) state_d = BANK;
        BANK: if (accept) begin
          if (strm.in_data >= 8'(NBANK)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wbank_d = strm.in_data[BANK_W-1:0];
            hold_d  = bank_onehot(strm.in_data[BANK_W-1:0]);
            state_d = COUNT;
          end
        end
        COUNT: if (accept) begin
          if ((strm.in_data == 8'd0) || (9'(strm.in_data) > 9'(DEPTH))) begin
            err_d   = 1'b1;
            hold_d  = '0;
            state_d = IDLE;
          end else begin
            cnt_d      = CNT_W'(strm.in_data);
            waddr_d    = '0;
            pack_clear = 1'b1;
            state_d    = DATA;
          end
        end
        DATA: begin
          byte_ok = accept;
          if (word_full) begin
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
        WRITE: begin
          waddr_d = waddr_q + AW'(1);
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? CSUM : DATA;
        end
        CSUM: if (accept) begin
          done_d  = (strm.in_data == csum);
          err_d   = (strm.in_data != csum);
          hold_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobe is registered; the abort gate only removes a write already in flight.
  assign we        = we_q && !abort;
  assign wbank     = wbank_q;
  assign waddr     = waddr_q;
  assign core_hold = hold_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by the driver, popped on we.
module tb_imem_loader;
  import imem_pkg::*;

  logic              clka = 1'b0;
  logic              rst_n = 1'b0;
  logic              abort = 1'b0;
  logic              we, busy, done, err;
  logic [BANK_W-1:0] wbank;
  logic [AW-1:0]     waddr;
  logic [31:0]       wdata;
  logic [NBANK-1:0]  core_hold;

  imem_loader_if s_if ();

  imem_loader dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .strm      (s_if),
    .abort     (abort),
    .we        (we),
    .wbank     (wbank),
    .waddr     (waddr),
    .wdata     (wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clka = ~clka;

  int unsigned      n_cmp = 0, n_mis = 0;
  int unsigned      n_done = 0, n_errp = 0, exp_done = 0, exp_err = 0;
  logic [47:0]      wq[$];
  logic [31:0]      fw[$];
  logic             in_write = 1'b0;
  logic [NBANK-1:0] exp_hold = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor away from the active edge
  always @(negedge clka) begin
    logic [47:0] e;
    chk("in_ready", 64'(s_if.in_ready), 64'(!in_write));
    chk("we", 64'(we), 64'(in_write && !abort));
    chk("core_hold", 64'(core_hold), 64'(exp_hold));
    if (we) begin
      if (wq.size() == 0) chk("we_unexpected", 64'(1), 64'(0));
      else begin
        e = wq.pop_front();
        chk("wbank", 64'(wbank), 64'(e[47:40]));
        chk("waddr", 64'(waddr), 64'(e[39:32]));
        chk("wdata", 64'(wdata), 64'(e[31:0]));
      end
    end
    if (done) n_done++;
    if (err)  n_errp++;
  end

  task automatic send_byte(input logic [7:0] b, input bit bp);
    logic        rdy;
    int unsigned n;
    if (bp && ($urandom_range(0, 1) == 1)) begin
      s_if.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clka);
      #1;
    end
    s_if.in_data  = b;
    s_if.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = s_if.in_ready;
      @(posedge clka);
      #1;
      n++;
    end while (!rdy && n < 64);
    if (!rdy) chk("xfer_timeout", 64'(0), 64'(1));
  endtask

  // Sends a frame from fw; abort_at >= 0 aborts in the WRITE cycle of that word.
  task automatic send_frame(input logic [7:0] bank, input bit flip, input bit bp, input int abort_at);
    logic [7:0] cs, b;
    cs = '0;
    send_byte(SYNC, bp);
    send_byte(bank, bp);
    exp_hold = bank_onehot(bank[BANK_W-1:0]);
    send_byte(8'(fw.size()), bp);
    for (int i = 0; i < fw.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = fw[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, bp);
      end
      in_write = 1'b1;
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clka);
        #1;
        abort    = 1'b0;
        in_write = 1'b0;
        exp_hold = '0;
        s_if.in_valid = 1'b0;
        chk("abort_err", 64'(err), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        exp_err++;
        return;
      end
      wq.push_back({8'(bank), 8'(i), fw[i]});
      @(posedge clka);
      #1;
      in_write = 1'b0;
    end
    send_byte(cs ^ 8'(flip), bp);
    exp_hold = '0;
    s_if.in_valid = 1'b0;
    chk("frame_done", 64'(done), 64'(!flip));
    chk("frame_err", 64'(err), 64'(flip));
    if (flip) exp_err++;
    else exp_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    s_if.in_data  = '0;
    s_if.in_valid = 1'b0;
    #3;
    chk("rst_in_ready", 64'(s_if.in_ready), 64'(1));
    chk("rst_outs", 64'({we, busy, done, err, core_hold, wbank, waddr, wdata}), 64'(0));
    @(posedge clka);
    @(posedge clka);
    #1 rst_n = 1'b1;

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    s_if.in_valid = 1'b0;
    chk("garbage_busy", 64'(busy), 64'(0));

    fw = '{32'h12345678};
    send_frame(8'd2, 0, 0, -1);

    send_byte(SYNC, 0);
    send_byte(8'd8, 0);
    s_if.in_valid = 1'b0;
    chk("bad_bank_err", 64'(err), 64'(1));
    exp_err++;
    send_byte(SYNC, 0);
    send_byte(8'd0, 0);
    exp_hold = bank_onehot(3'd0);
    send_byte(8'd0, 0);
    exp_hold = '0;
    s_if.in_valid = 1'b0;
    chk("cnt0_err", 64'(err), 64'(1));
    exp_err++;
    send_byte(SYNC, 0);
    send_byte(8'd5, 0);
    exp_hold = bank_onehot(3'd5);
    send_byte(8'd129, 0);
    exp_hold = '0;
    s_if.in_valid = 1'b0;
    chk("cnt129_err", 64'(err), 64'(1));
    exp_err++;

    fw = '{32'hDEADBEEF, 32'h0BADF00D};
    send_frame(8'd4, 1, 0, -1);

    fw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_frame(8'd3, 0, 0, 2);

    abort = 1'b1;
    @(posedge clka);
    #1 abort = 1'b0;
    chk("idle_abort_err", 64'(err), 64'(0));

    send_byte(SYNC, 0);
    send_byte(8'd1, 0);
    exp_hold = bank_onehot(3'd1);
    send_byte(8'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    exp_hold = '0;
    s_if.in_valid = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(s_if.in_ready), 64'(1));
    chk("mid_rst_outs", 64'({we, busy, done, err, core_hold, wbank, waddr, wdata}), 64'(0));
    @(posedge clka);
    @(posedge clka);
    #1 rst_n = 1'b1;

    fw = '{32'hCAFEF00D, 32'hA5A5A5A5};
    send_frame(8'd6, 0, 0, -1);

    fw.delete();
    for (int i = 0; i < DEPTH; i++) fw.push_back(32'(i));
    send_frame(8'd7, 0, 0, -1);

    fw = '{32'h03020100, 32'h07060504, 32'hA50B0A09, 32'h0F0E0D0C};
    send_frame(8'd0, 0, 0, -1);
    send_frame(8'd0, 0, 1, -1);

    repeat (3) @(posedge clka);
    #1;
    chk("final_busy", 64'(busy), 64'(0));
    chk("wq_left", 64'(wq.size()), 64'(0));
    chk("n_done", 64'(n_done), 64'(exp_done));
    chk("n_err", 64'(n_errp), 64'(exp_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the 8-bank instruction memory.
- Accepts a framed byte stream over a valid/ready handshake, e.g. from a UART RX or a debug bridge.
- Assembles little-endian 32-bit instruction words and drives a single write port (bank, word address, data, write enable) into the selected bank's instruction RAM.
- While a bank is being loaded, holds that bank's core in stall, and reports done or error.

Parameters:
- NBANK, 8, number of instruction-memory banks (cores); the bank index is 3 bits.
- AW, 7, word-address width per bank; bank depth is 2^AW = 128 words.
- SYNC, 8'hA5, frame start byte.

Ports:
- clka  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- abort  in  1  synchronous abort; returns to IDLE.
- we  out  1  one-cycle write strobe.
- wbank  out  3  target bank, 0..NBANK-1.
- waddr  out  AW  word address within the bank; the RAM byte address is waddr<<2.
- wdata  out  32  instruction word.
- core_hold  out  NBANK  one-hot stall for the bank under load.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the frame completes with a good checksum.
- err  out  1  one-cycle pulse on a header or checksum error, or on abort.

Behaviour:
- Reset:
  - Reset is asynchronous; all outputs go to 0 except in_ready, which is 1.
  - State goes to IDLE, and all counters and the checksum clear.
  - Reset mid-frame discards any partial word. Words already written stay in the RAM.
- Frame format, byte order: SYNC, BANK, COUNT, then COUNT×4 data bytes (LSB first per word), then CSUM.
  - CSUM = XOR of all data bytes.
  - COUNT range is 1..2^AW.
- State machine:
  - IDLE: bytes other than SYNC are dropped silently. SYNC → BANK.
  - BANK: byte ≥ NBANK → err pulse, go to IDLE. Otherwise latch wbank, assert core_hold[wbank], go to COUNT.
  - COUNT: byte == 0 or > 2^AW → err pulse, drop core_hold, go to IDLE. Otherwise latch the word count, set waddr = 0, clear the checksum and byte index, go to DATA.
  - DATA:
    - Byte index k (0..3) places the byte at wdata[8k+7:8k], and the byte is XORed into the checksum.
    - On acceptance of k = 3, go to WRITE.
  - WRITE (exactly one cycle):
    - we = 1; in_ready = 0, so each word costs one bubble cycle.
    - Then waddr increments and the remaining word count decrements.
    - If the remaining count is now 0 → CSUM, else → DATA.
  - CSUM: compare the byte to the checksum.
    - Match → done pulse.
    - Mismatch → err pulse.
    - Either way, core_hold drops to 0 in the same cycle as the pulse, then go to IDLE.
- Output timing:
  - we, done and err are registered outputs.
  - Latency from acceptance of a word's 4th byte to we high is one cycle.
  - wdata, waddr and wbank are stable while we is high.
- in_ready is 1 in every state except WRITE.
- waddr never wraps: COUNT ≤ 2^AW guarantees the last write is at address 2^AW−1. The increment after the last word is don't-care and is not observable on the outputs.
- abort:
  - In any non-IDLE state: err pulse, clear core_hold, go to IDLE next cycle.
  - abort takes priority over a byte transferred in the same cycle, and that byte is discarded.
  - If abort lands in WRITE, the write in that cycle is suppressed (we = 0).
  - In IDLE, abort has no effect and raises no err.
- in_valid low stalls any state indefinitely; there is no timeout.
- A SYNC value inside the payload is treated as data, not as a resync.

Decomposition:
- Shared package imem_pkg:
  - constants NBANK, AW, SYNC;
  - state encoding IDLE/BANK/COUNT/DATA/WRITE/CSUM;
  - the bank-index width.
- One natural sub-module: imem_word_pack.
  - Holds the byte index counter, the shift/insert into the 32-bit word, and the running XOR.
  - Signals: byte_ok/word_full/clear.
  - The top level holds the FSM, the address and count counters, and the outputs.

Test Plan:
- Single word: A5,02,01,78,56,34,12,CSUM=08 with in_valid held high → one we with wbank=2, waddr=0, wdata=32'h12345678; done 1 cycle after CSUM; core_hold=8'b00000100 from BANK until the done cycle.
- Full bank: bank 7, COUNT=128, data = word index i (bytes i,0,0,0) → 128 we pulses at waddr 0..127; in_ready low exactly on each WRITE cycle; done; no address wrap.
- Bad header: A5,08 → err pulse, no we; then A5,00,00 (COUNT=0) → err; core_hold=0 after each error; leading garbage bytes 00,FF before A5 are ignored.
- Checksum error: valid 2-word frame with CSUM xor 1 → both words written, err pulse (no done), core_hold cleared.
- Abort and reset: abort asserted in the WRITE cycle of word 3 → no we that cycle, err pulse, IDLE. Separately, rst_n low mid-DATA → all outputs 0 immediately, in_ready 1; a following good frame loads correctly.
- Backpressure: in_valid toggled randomly during a 4-word frame → wdata/waddr identical to the back-to-back case; done still asserted.
